// File: rtl/apb_cmd_master.sv
// Purpose: turns a valid/ready command stream into single APB transfers, with an ACCESS-phase timeout.
// Latency: command accepted in cycle N -> PSEL in N+1, penable in N+2, rsp_valid in N+3 (zero-wait slave).
// Backpressure: one transfer in flight; cmd_ready stays low from acceptance until the response handshake.
module apb_cmd_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  PClk,
  input  logic                  PRESETn,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_tmo,
  // APB requester side
  output logic                  PSEL,
  output logic [ADDR_WIDTH-3:0] pAddr,
  output logic                  penable,
  output logic                  PWRite,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  // Counter holds the number of ACCESS cycles already completed; a width of at
  // least one bit keeps the no-timeout build (TIMEOUT_CYC = 0) legal.
  localparam int CW         = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam int TMO_LAST_I = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [CW-1:0] TMO_LAST = TMO_LAST_I[CW-1:0];
  localparam bit TMO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-3:0]   paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    rsp_tmo_q, rsp_tmo_d;

  // Byte-lane bits of the command address carry no meaning on a word bus.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^cmd_addr[1:0];

  // Next-state logic; every output is derived from the next state so it leaves a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;

    unique case (state_q)
      S_IDLE: begin
        // cmd_ready_q is low for the first cycle after reset, so nothing is taken then.
        if (cmd_ready_q && cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr[ADDR_WIDTH-1:2];
          pwdata_d = cmd_wdata;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        if (pready) begin
          // A completing slave beats a simultaneous timeout.
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          rsp_tmo_d   = 1'b0;
          state_d     = S_RESP;
        end else if (TMO_EN && (cnt_q == TMO_LAST)) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_tmo_d   = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge PClk) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign penable   = penable_q;
  assign PWRite    = pwrite_q;
  assign pAddr     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed scenarios plus randomized commands against a transaction-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The bench plays both the command source and the APB slave, with configurable wait states.
module tb_apb_cmd_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          PClk;
  logic          PRESETn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_tmo;
  logic          PSEL;
  logic [AW-3:0] pAddr;
  logic          penable;
  logic          PWRite;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  int n_vec;
  int n_err;

  apb_cmd_master #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .PClk      (PClk),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_tmo   (rsp_tmo),
    .PSEL      (PSEL),
    .pAddr     (pAddr),
    .penable   (penable),
    .PWRite    (PWRite),
    .PWDATA    (PWDATA),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  initial PClk = 1'b0;
  always #5 PClk = ~PClk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete command. The expected response comes from the transaction rules:
  // the slave raises pready after `waits` wait cycles; if that would need more than
  // TMO ACCESS cycles the transfer times out instead.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int waits, input bit serr,
                         input int hold, input bit pester);
    int          len;
    bit          tmo;
    bit          exp_err;
    logic [31:0] exp_rdata;
    logic [29:0] exp_word;
    int          budget;

    tmo       = (waits >= TMO);
    len       = tmo ? TMO : waits + 1;
    exp_err   = tmo || serr;
    exp_rdata = (tmo || wr) ? 32'h0 : rd;
    exp_word  = addr[31:2];

    budget = 0;
    while (cmd_ready !== 1'b1 && budget < 8) begin
      @(negedge PClk);
      budget++;
    end
    chk("idle_cmd_ready", cmd_ready, 1);

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge PClk);
    // Optionally keep presenting junk to prove commands are ignored while busy.
    if (pester) begin
      cmd_write = ~wr;
      cmd_addr  = $urandom;
      cmd_wdata = $urandom;
    end else begin
      cmd_valid = 1'b0;
    end

    chk("setup_psel", PSEL, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", pAddr, exp_word);
    chk("setup_pwrite", PWRite, wr);
    if (wr) chk("setup_pwdata", PWDATA, wdata);
    chk("setup_cmd_ready", cmd_ready, 0);
    chk("setup_rsp_valid", rsp_valid, 0);
    @(negedge PClk);

    for (int k = 0; k < len; k++) begin
      chk("access_psel", PSEL, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", pAddr, exp_word);
      chk("access_pwrite", PWRite, wr);
      if (wr) chk("access_pwdata", PWDATA, wdata);
      chk("access_cmd_ready", cmd_ready, 0);
      chk("access_rsp_valid", rsp_valid, 0);
      pready  = (k == waits);
      prdata  = (k == waits) ? rd : $urandom;
      pslverr = (k == waits) ? serr : 1'($urandom);
      @(negedge PClk);
    end
    pready  = 1'b0;
    prdata  = $urandom;
    pslverr = 1'($urandom);

    for (int h = 0; h <= hold; h++) begin
      chk("resp_valid", rsp_valid, 1);
      chk("resp_rdata", rsp_rdata, exp_rdata);
      chk("resp_err", rsp_err, exp_err);
      chk("resp_tmo", rsp_tmo, tmo);
      chk("resp_psel", PSEL, 0);
      chk("resp_penable", penable, 0);
      chk("resp_cmd_ready", cmd_ready, 0);
      rsp_ready = (h == hold);
      @(negedge PClk);
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // Reset values.
    repeat (3) @(negedge PClk);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_tmo", rsp_tmo, 0);
    chk("rst_paddr", pAddr, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_pwrite", PWRite, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    PRESETn = 1'b1;
    @(negedge PClk);
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Zero-wait write.
    run_cmd(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0);
    // Read with three wait states.
    run_cmd(1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 1'b0, 0, 1'b0);
    // Read that ends in a slave error.
    run_cmd(1'b0, 32'h0000_0034, 32'h0, 32'hCAFE_F00D, 1, 1'b1, 0, 1'b0);
    // Slave never ready: timeout after TMO ACCESS cycles.
    run_cmd(1'b0, 32'h0000_0040, 32'h0, 32'h1111_2222, 1000, 1'b0, 0, 1'b0);
    // Ready on the last allowed ACCESS cycle: normal completion.
    run_cmd(1'b0, 32'h0000_0044, 32'h0, 32'h3333_4444, TMO - 1, 1'b0, 0, 1'b0);
    // Response held off for 10 cycles while a second command is presented.
    run_cmd(1'b1, 32'h0000_0100, 32'h0F0F_F0F0, 32'h5555_6666, 2, 1'b0, 10, 1'b1);

    // Reset in the middle of ACCESS drops the transfer.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h0000_0080;
    @(negedge PClk);
    cmd_valid = 1'b0;
    @(negedge PClk);
    chk("midrst_pre_penable", penable, 1);
    PRESETn = 1'b0;
    @(negedge PClk);
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 0);
    PRESETn = 1'b1;
    @(negedge PClk);
    chk("midrst_release_cmd_ready", cmd_ready, 1);
    run_cmd(1'b0, 32'h0000_0088, 32'h0, 32'h8765_4321, 0, 1'b0, 0, 1'b0);

    // Randomized commands.
    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 20),
              1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
